// File: rtl/universal_shift_reg_if.sv
// Bundle of the control, data and status signals of universal_shift_reg.
// The master modport drives the controls; the slave modport is the register side.
interface universal_shift_reg_if #(
  parameter int WIDTH = 8
) ();
  localparam int CW = $clog2(WIDTH + 1);

  logic             en;
  logic [1:0]       mode;
  logic             sin_right;
  logic             sin_left;
  logic             rotate;
  logic [WIDTH-1:0] pdata_in;
  logic [WIDTH-1:0] q;
  logic             sout_right;
  logic             sout_left;
  logic [CW-1:0]    bit_cnt;
  logic             frame_done;

  modport master (
    output en, mode, sin_right, sin_left, rotate, pdata_in,
    input  q, sout_right, sout_left, bit_cnt, frame_done
  );

  modport slave (
    input  en, mode, sin_right, sin_left, rotate, pdata_in,
    output q, sout_right, sout_left, bit_cnt, frame_done
  );
endinterface

// File: rtl/universal_shift_reg.sv
// Universal shift register (hold / shift right / shift left / parallel load) with a
// saturating shift counter and frame-done pulse. Define ROTATE_EN to enable rotation.
module universal_shift_reg #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  universal_shift_reg_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_RIGHT = 2'b01,
    MODE_LEFT  = 2'b10,
    MODE_LOAD  = 2'b11
  } mode_e;

  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             frame_done_q, frame_done_d;
  logic             right_in, left_in;
  mode_e            mode;

  assign mode = mode_e'(bus.mode);

`ifdef ROTATE_EN
  assign right_in = bus.rotate ? q_q[0]       : bus.sin_right;
  assign left_in  = bus.rotate ? q_q[WIDTH-1] : bus.sin_left;
`else
  logic unused_rotate;
  assign unused_rotate = bus.rotate;
  assign right_in      = bus.sin_right;
  assign left_in       = bus.sin_left;
`endif

  always_comb begin
    q_d          = q_q;
    bit_cnt_d    = bit_cnt_q;
    frame_done_d = 1'b0;
    if (bus.en) begin
      case (mode)
        MODE_RIGHT: q_d = {right_in, q_q[WIDTH-1:1]};
        MODE_LEFT:  q_d = {q_q[WIDTH-2:0], left_in};
        MODE_LOAD: begin
          q_d       = bus.pdata_in;
          bit_cnt_d = '0;
        end
        default: ;
      endcase
      // Both shift directions advance the same counter; it saturates at WIDTH.
      if ((mode == MODE_RIGHT || mode == MODE_LEFT) && bit_cnt_q != CW'(WIDTH)) begin
        bit_cnt_d    = bit_cnt_q + CW'(1);
        frame_done_d = (bit_cnt_q == CW'(WIDTH - 1));
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q          <= RESET_VALUE;
      bit_cnt_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      q_q          <= q_d;
      bit_cnt_q    <= bit_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.q          = q_q;
  assign bus.sout_right = q_q[0];
  assign bus.sout_left  = q_q[WIDTH-1];
  assign bus.bit_cnt    = bit_cnt_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_universal_shift_reg.sv
// Scoreboard bench for universal_shift_reg: a behavioural model pushes expected state
// when stimulus is driven, and the entry is popped and compared after the clock edge.
module tb_universal_shift_reg;
  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  typedef struct packed {
    logic [W-1:0]  q;
    logic [CW-1:0] cnt;
    logic          done;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  universal_shift_reg_if #(.WIDTH(W)) bus ();

  universal_shift_reg #(
    .WIDTH(W),
    .RESET_VALUE('0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  exp_t          expQ[$];
  logic [W-1:0]  modelQ;
  logic [CW-1:0] modelCnt;
  logic          modelDone;
  int            checks   = 0;
  int            failures = 0;
  int            pulses;
  logic [7:0]    soutSeq;

  // Every comparison in the bench funnels through here.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of controls, push the model's next state, then compare after the edge.
  task automatic applyStimulus(input logic en, input logic [1:0] mode, input logic sr,
                               input logic sl, input logic rot, input logic [W-1:0] pd,
                               input string tag);
    logic rb, lb;
    exp_t e;
    bus.en        = en;
    bus.mode      = mode;
    bus.sin_right = sr;
    bus.sin_left  = sl;
    bus.rotate    = rot;
    bus.pdata_in  = pd;
`ifdef ROTATE_EN
    rb = rot ? modelQ[0]   : sr;
    lb = rot ? modelQ[W-1] : sl;
`else
    rb = sr;
    lb = sl;
`endif
    modelDone = 1'b0;
    if (en) begin
      if (mode == 2'b11) begin
        modelQ   = pd;
        modelCnt = '0;
      end else if (mode != 2'b00) begin
        if (mode == 2'b01) modelQ = {rb, modelQ[W-1:1]};
        else               modelQ = {modelQ[W-2:0], lb};
        if (int'(modelCnt) < W) begin
          modelCnt++;
          if (int'(modelCnt) == W) modelDone = 1'b1;
        end
      end
    end
    expQ.push_back('{q: modelQ, cnt: modelCnt, done: modelDone});
    @(posedge clk);
    #1;
    e = expQ.pop_front();
    checkOutput({tag, ".q"},          bus.q,          e.q);
    checkOutput({tag, ".bit_cnt"},    bus.bit_cnt,    e.cnt);
    checkOutput({tag, ".frame_done"}, bus.frame_done, e.done);
    checkOutput({tag, ".sout_right"}, bus.sout_right, e.q[0]);
    checkOutput({tag, ".sout_left"},  bus.sout_left,  e.q[W-1]);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, ".q"},          bus.q,          0);
    checkOutput({tag, ".bit_cnt"},    bus.bit_cnt,    0);
    checkOutput({tag, ".frame_done"}, bus.frame_done, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    reset         = 1'b0;
    bus.en        = 1'b0;
    bus.mode      = 2'b00;
    bus.sin_right = 1'b0;
    bus.sin_left  = 1'b0;
    bus.rotate    = 1'b0;
    bus.pdata_in  = '0;
    modelQ = '0; modelCnt = '0; modelDone = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkResetState("por");
    reset = 1'b1;

    $display("[TB] async reset mid-operation");
    applyStimulus(1, 2'b11, 0, 0, 0, 8'h5A, "t1.load");
    applyStimulus(1, 2'b01, 1, 0, 0, 8'h00, "t1.sh1");
    applyStimulus(1, 2'b01, 1, 0, 0, 8'h00, "t1.sh2");
    #2;
    reset = 1'b0;
    #1;
    checkResetState("t1.async");
    @(posedge clk);
    #1;
    checkResetState("t1.held");
    reset = 1'b1;
    modelQ = '0; modelCnt = '0; modelDone = 1'b0;

    $display("[TB] load 0xA5 then serialize right");
    applyStimulus(1, 2'b11, 0, 0, 0, 8'hA5, "t2.load");
    soutSeq = {7'b0, bus.sout_right};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 2'b01, 0, 0, 0, 8'h00, "t2.shift");
      if (i < 7) soutSeq = {soutSeq[6:0], bus.sout_right};
    end
    checkOutput("t2.sout_seq", soutSeq, 8'hA5);
    checkOutput("t2.final_q", bus.q, 8'h00);
    checkOutput("t2.final_cnt", bus.bit_cnt, 8);
    checkOutput("t2.pulse", bus.frame_done, 1);
    applyStimulus(1, 2'b00, 0, 0, 0, 8'h00, "t2.after");

    $display("[TB] shift left from zero");
    applyStimulus(1, 2'b11, 0, 0, 0, 8'h00, "t3.load");
    applyStimulus(1, 2'b10, 0, 1, 0, 8'h00, "t3.l1");
    applyStimulus(1, 2'b10, 0, 1, 0, 8'h00, "t3.l2");
    applyStimulus(1, 2'b10, 0, 0, 0, 8'h00, "t3.l3");
    applyStimulus(1, 2'b10, 0, 1, 0, 8'h00, "t3.l4");
    checkOutput("t3.q", bus.q, 8'h0D);
    checkOutput("t3.cnt", bus.bit_cnt, 4);

    $display("[TB] clock enable hold");
    applyStimulus(1, 2'b11, 0, 0, 0, 8'h3C, "t4.load");
    for (int i = 0; i < 3; i++) applyStimulus(0, 2'b01, 1, 1, 0, 8'hFF, "t4.en0");
    checkOutput("t4.held_q", bus.q, 8'h3C);
    applyStimulus(1, 2'b01, 0, 0, 0, 8'h00, "t4.resume");
    checkOutput("t4.q", bus.q, 8'h1E);

    $display("[TB] saturation");
    applyStimulus(1, 2'b11, 0, 0, 0, 8'hFF, "t5.load");
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 2'b01, 0, 0, 0, 8'h00, "t5.shift");
      if (bus.frame_done) pulses++;
    end
    checkOutput("t5.cnt", bus.bit_cnt, 8);
    checkOutput("t5.pulses", pulses, 1);
    applyStimulus(1, 2'b11, 0, 0, 0, 8'h00, "t5.reload");
    checkOutput("t5.cnt_clr", bus.bit_cnt, 0);

    $display("[TB] rotation");
    applyStimulus(1, 2'b11, 0, 0, 0, 8'h81, "t6.load");
    applyStimulus(1, 2'b01, 0, 0, 1, 8'h00, "t6.rotr");
`ifdef ROTATE_EN
    checkOutput("t6.rotr_q", bus.q, 8'hC0);
`else
    checkOutput("t6.rotr_q", bus.q, 8'h40);
`endif
    applyStimulus(1, 2'b11, 0, 0, 0, 8'h81, "t6.load2");
    applyStimulus(1, 2'b10, 0, 0, 1, 8'h00, "t6.rotl");
`ifdef ROTATE_EN
    checkOutput("t6.rotl_q", bus.q, 8'h03);
`else
    checkOutput("t6.rotl_q", bus.q, 8'h02);
`endif

    $display("[TB] random mixed traffic");
    for (int i = 0; i < 60; i++) begin
      applyStimulus(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), "rnd");
    end

    checkOutput("scoreboard_empty", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/universal_shift_reg.md
Name: universal_shift_reg

Overview:
Parametrised universal shift register, the successor to the fixed single-bit SISO shifter. Supports hold, shift right, shift left and parallel load on one register. Provides serial outputs at both ends and a bit counter with a frame-done pulse, so the block can act as a WIDTH-bit serializer or deserializer in the shift_registers family.

Parameters:
WIDTH, 8, register width in bits; legal range WIDTH >= 2
RESET_VALUE, 0, value loaded into q on reset (WIDTH bits)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = in reset)
en  input  1  clock enable; 0 holds all state
mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load
sin_right  input  1  serial bit entering q[WIDTH-1] on shift right
sin_left  input  1  serial bit entering q[0] on shift left
rotate  input  1  rotate select (active only with ROTATE_EN)
pdata_in  input  WIDTH  parallel load data
q  output  WIDTH  register contents
sout_right  output  1  q[0], combinational from q
sout_left  output  1  q[WIDTH-1], combinational from q
bit_cnt  output  $clog2(WIDTH+1)  shifts since last load or reset, saturating
frame_done  output  1  one-cycle pulse when bit_cnt reaches WIDTH

Behaviour:
- Reset (reset=0): immediately, with no clock edge needed, q=RESET_VALUE, bit_cnt=0, frame_done=0. This holds even mid-operation. Release is synchronous to the next clk edge.
- All updates occur on the rising clk edge, only when en=1.
- When en=0: q and bit_cnt hold; frame_done=0 on that edge.
- mode 00: q holds; bit_cnt holds; frame_done=0.
- mode 01: q <= {sin_right, q[WIDTH-1:1]}.
- mode 10: q <= {q[WIDTH-2:0], sin_left}.
- mode 11: q <= pdata_in; bit_cnt <= 0; frame_done <= 0.
- On each shift edge (mode 01/10, en=1):
  - If bit_cnt < WIDTH, bit_cnt increments.
  - If bit_cnt == WIDTH, it saturates and holds.
- frame_done is registered:
  - It goes to 1 on the same edge where bit_cnt transitions WIDTH-1 -> WIDTH.
  - It goes to 0 on every other edge, so it is exactly one cycle wide.
  - A saturated counter produces no further pulses until the next load or reset.
- Latency:
  - Parallel-loaded q[0] is visible on sout_right in the cycle after the load edge.
  - Each subsequent bit appears one cycle after each right shift.
- Counting from reset: shifts after reset count exactly like shifts after a load.
- Direction changes mid-frame are legal. Right and left shifts both increment the same counter.

Optional Feature:
ROTATE_EN
- Defined:
  - mode 01 with rotate=1 gives q <= {q[0], q[WIDTH-1:1]}.
  - mode 10 with rotate=1 gives q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - sin_right and sin_left are ignored while rotating.
  - bit_cnt and frame_done behave as for a normal shift.
- Not defined: the rotate input is ignored, and all shifts use sin_right and sin_left.

Test Plan:
1. While shifting from q=0x5A, drive reset=0 between clock edges -> q=0x00 (RESET_VALUE=0), bit_cnt=0, frame_done=0 before the next edge. The state holds while reset=0.
2. Load: en=1, mode=11, pdata_in=0xA5, then 8 cycles of mode=01 with sin_right=0.
   - sout_right sequence is 1,0,1,0,0,1,0,1.
   - Final q=0x00 and bit_cnt=8.
   - frame_done is high for exactly the cycle after the 8th shift edge.
3. From q=0x00, apply mode=10 with sin_left=1,1,0,1 -> q=0x0D and bit_cnt=4. frame_done stays 0.
4. With q=0x3C, set mode=01 and en=0 for 3 cycles -> q stays 0x3C, bit_cnt unchanged, frame_done=0. Raising en resumes shifting, giving q=0x1E with sin_right=0.
5. Load 0xFF, then 10 right shifts -> bit_cnt saturates at 8 with exactly one frame_done pulse. Reloading 0x00 clears bit_cnt to 0.
6. Rotation, WIDTH=8, q=0x81, rotate=1:
   - With ROTATE_EN, mode=01 gives 0xC0; mode=10 from 0x81 gives 0x03.
   - Without ROTATE_EN, mode=01 with sin_right=0 gives 0x40.
